lt_sequencer: RTL

- Controller for the latency-tester path of the internal 720x480 test-pattern generator.
- Drives the generator's lt_active/lt_mode inputs and arms the pattern on a frame boundary.
- Times the interval from patch switch-on to the optical sensor detecting light, in microseconds.
- Sits between the CPU-side control registers (start/abort/mode, result readback) and the pattern generator.

---
 rtl/lt_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/lt_sequencer.sv
// lt_sequencer: latency-tester controller for the 720x480 test-pattern generator.
// Arms a black screen, waits for ARM_FRAMES consecutive dark frames, switches the
// patch on at a frame boundary and times switch-on to photodiode detection in us.
// Build option: define LT_AVG4_EN to average four ARM->MEASURE passes per start.
module lt_sequencer #(
    parameter int unsigned CLKS_PER_US = 27,
    parameter logic [15:0] TIMEOUT_US  = 16'd50000,
    parameter int unsigned ARM_FRAMES  = 3
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  mode_sel,
    input  logic        vsync_in,
    input  logic        sensor_in,
    output logic        lt_active,
    output logic [1:0]  lt_mode,
    output logic        busy,
    output logic        result_valid,
    output logic        timeout,
    output logic [15:0] lat_result
);

    localparam int unsigned PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam int unsigned FW = $clog2(ARM_FRAMES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_US - 1);
    localparam logic [FW-1:0] ARM_LAST   = FW'(ARM_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            sens_m;
    logic            sens_s;
    logic            vsync_r;
    logic            vsync_d;
    logic            frame_start;
    logic [1:0]      mode_r;
    logic [FW-1:0]   frm_cnt;
    logic [FW-1:0]   frm_inc;
    logic [PW-1:0]   presc;
    logic [15:0]     us_cnt;
    logic            us_timeout;
    logic            accept_start;

`ifdef LT_AVG4_EN
    logic [1:0]      pass_cnt;
    logic [17:0]     acc;
    logic [17:0]     acc_sum;
    assign acc_sum = acc + {2'b00, us_cnt};
`endif

    assign frame_start  = vsync_d & ~vsync_r;
    assign frm_inc      = frm_cnt + 1'b1;
    assign us_timeout   = (us_cnt == TIMEOUT_US);
    assign accept_start = start & ~abort;
    assign busy         = (state != ST_IDLE);
    assign lt_active    = (state == ST_ARM) || (state == ST_MEASURE);

    // Input synchronisers: 2-FF for the photodiode, edge detector on VSYNC
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            sens_m  <= 1'b0;
            sens_s  <= 1'b0;
            vsync_r <= 1'b0;
            vsync_d <= 1'b0;
        end else begin
            sens_m  <= sensor_in;
            sens_s  <= sens_m;
            vsync_r <= vsync_in;
            vsync_d <= vsync_r;
        end
    end

    // State register
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; abort overrides every busy-state transition
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept_start) begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (frame_start && !sens_s && (frm_inc == ARM_LAST)) begin
                    state_next = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (sens_s) begin
`ifdef LT_AVG4_EN
                    state_next = (pass_cnt == 2'd3) ? ST_DONE : ST_ARM;
`else
                    state_next = ST_DONE;
`endif
                end else if (us_timeout) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath: frame counter, us timer, result registers, patch mode
    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            mode_r       <= '0;
            lt_mode      <= '0;
            frm_cnt      <= '0;
            presc        <= '0;
            us_cnt       <= '0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            lat_result   <= '0;
`ifdef LT_AVG4_EN
            pass_cnt     <= '0;
            acc          <= '0;
`endif
        end else begin
            // Patch appears on the same edge MEASURE is entered, black otherwise
            lt_mode <= (state_next == ST_MEASURE) ? mode_r : 2'b00;
            case (state)
                ST_IDLE: begin
                    if (accept_start) begin
                        mode_r       <= mode_sel;
                        result_valid <= 1'b0;
                        timeout      <= 1'b0;
                        frm_cnt      <= '0;
`ifdef LT_AVG4_EN
                        pass_cnt     <= '0;
                        acc          <= '0;
`endif
                    end
                end
                ST_ARM: begin
                    presc  <= '0;
                    us_cnt <= '0;
                    if (frame_start) begin
                        frm_cnt <= sens_s ? '0 : frm_inc;
                    end
                end
                ST_MEASURE: begin
                    if (!abort) begin
                        if (presc == PRESC_LAST) begin
                            presc <= '0;
                            if (!us_timeout) begin
                                us_cnt <= us_cnt + 16'd1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                        if (sens_s) begin
`ifdef LT_AVG4_EN
                            if (pass_cnt == 2'd3) begin
                                lat_result <= acc_sum[17:2];
                            end else begin
                                acc      <= acc_sum;
                                pass_cnt <= pass_cnt + 2'd1;
                                frm_cnt  <= '0;
                            end
`else
                            lat_result <= us_cnt;
`endif
                        end else if (us_timeout) begin
                            lat_result <= 16'hFFFF;
                            timeout    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (!abort) begin
                        result_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
